// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, response owner tag,
// the default memory size and the address range check.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DMA_OWN = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam int unsigned DMEM_BYTES_DEF = 8192;

    function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned limit);
        return addr < {32'b0, limit};
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the single-port data memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, cpu_err,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_resp_router.sv
// Registers who owned last cycle's grant and steers the one-cycle-late read data
// and error flag back to that requester only.
module dmem_resp_router
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_gnt_i,
    input  logic              dma_gnt_i,
    input  logic              we_i,
    input  logic              oor_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              cpu_rvalid_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_err_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_err_o
);

    owner_e owner_q, owner_d;
    logic   valid_q, valid_d;
    logic   err_q, err_d;
    logic   any_gnt;
    logic [DATA_W-1:0] rd_data;

    assign any_gnt = cpu_gnt_i || dma_gnt_i;

    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_gnt_i) begin
            owner_d = OWN_CPU;
        end else if (dma_gnt_i) begin
            owner_d = OWN_DMA;
        end
        valid_d = any_gnt && !we_i;
        err_d   = any_gnt && oor_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Out-of-range reads never reached memory, so whatever it drives is stale.
    assign rd_data = err_q ? '0 : mem_rdata_i;

    assign cpu_rvalid_o = valid_q && (owner_q == OWN_CPU);
    assign dma_rvalid_o = valid_q && (owner_q == OWN_DMA);
    assign cpu_rdata_o  = cpu_rvalid_o ? rd_data : '0;
    assign dma_rdata_o  = dma_rvalid_o ? rd_data : '0;
    assign cpu_err_o    = err_q && (owner_q == OWN_CPU);
    assign dma_err_o    = err_q && (owner_q == OWN_DMA);

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/DMA arbiter in front of a single-port data memory, with DMA burst limiting.
//   state   | meaning
//   IDLE    | no grant last cycle; CPU has priority
//   CPU_OWN | CPU granted last cycle; DMA has priority
//   DMA_OWN | DMA granted last cycle; DMA keeps the port until BURST_MAX if CPU waits
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 64,
    parameter int          BURST_MAX  = 4,
    parameter int unsigned DMEM_BYTES = DMEM_BYTES_DEF
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              burst_done;
    logic              cpu_win, dma_win;
    logic              cpu_gnt, dma_gnt, any_gnt;
    logic              sel_we, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign burst_done = (burst_cnt_q >= CNT_W'(BURST_MAX));

    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        case (state_q)
            CPU_OWN: begin
                dma_win = bus.dma_req;
                cpu_win = bus.cpu_req && !bus.dma_req;
            end
            DMA_OWN: begin
                dma_win = bus.dma_req && !(burst_done && bus.cpu_req);
                cpu_win = bus.cpu_req && !dma_win;
            end
            default: begin
                cpu_win = bus.cpu_req;
                dma_win = bus.dma_req && !bus.cpu_req;
            end
        endcase
    end

    // Grants are forced low the instant reset asserts, independent of the clock.
    assign cpu_gnt = cpu_win && rst;
    assign dma_gnt = dma_win && rst;
    assign any_gnt = cpu_gnt || dma_gnt;

    always_comb begin
        state_d = IDLE;
        if (cpu_gnt) begin
            state_d = CPU_OWN;
        end else if (dma_gnt) begin
            state_d = DMA_OWN;
        end
        burst_cnt_d = '0;
        if (dma_gnt) begin
            burst_cnt_d = burst_done ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        if (cpu_gnt) begin
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
            sel_we    = bus.cpu_we;
        end else if (dma_gnt) begin
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
            sel_we    = bus.dma_we;
        end
    end

    assign in_range = addr_in_range(64'(sel_addr), DMEM_BYTES);

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dma_gnt   = dma_gnt;
    assign bus.cpu_stall = bus.cpu_req && !cpu_gnt;
    assign bus.mem_en    = any_gnt && in_range;
    assign bus.mem_we    = sel_we;
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    dmem_resp_router #(
        .DATA_W (DATA_W)
    ) u_router (
        .clk          (clk),
        .rst          (rst),
        .cpu_gnt_i    (cpu_gnt),
        .dma_gnt_i    (dma_gnt),
        .we_i         (sel_we),
        .oor_i        (!in_range),
        .mem_rdata_i  (bus.mem_rdata),
        .cpu_rvalid_o (bus.cpu_rvalid),
        .cpu_rdata_o  (bus.cpu_rdata),
        .cpu_err_o    (bus.cpu_err),
        .dma_rvalid_o (bus.dma_rvalid),
        .dma_rdata_o  (bus.dma_rdata),
        .dma_err_o    (bus.dma_err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: expected grants per step, read responses via a scoreboard queue.
module tb_dmem_arbiter;

    localparam int unsigned MEM_BYTES = 8192;

    typedef struct {
        logic        cv;
        logic [63:0] cd;
        logic        ce;
        logic        dv;
        logic [63:0] dd;
        logic        de;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst;
    resp_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic [63:0] wmem [int];

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (64),
        .BURST_MAX  (4),
        .DMEM_BYTES (MEM_BYTES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [63:0] mem_init(input int idx);
        case (idx)
            4:       return 64'hAAAA;
            5:       return 64'hBBBB;
            default: return {32'hC0DE_0000, 32'(idx)};
        endcase
    endfunction

    // Memory model: one-cycle read latency, writes tracked sparsely.
    always @(posedge clk) begin
        int idx;
        idx = int'(bus.mem_addr[12:3]);
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                wmem[idx] = bus.mem_wdata;
            end else begin
                bus.mem_rdata <= wmem.exists(idx) ? wmem[idx] : mem_init(idx);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_resp(input string tag);
        resp_t e;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL %s.sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, ".cpu_rvalid"}, 64'(bus.cpu_rvalid), 64'(e.cv));
            chk({tag, ".cpu_rdata"},  bus.cpu_rdata,       e.cd);
            chk({tag, ".cpu_err"},    64'(bus.cpu_err),    64'(e.ce));
            chk({tag, ".dma_rvalid"}, 64'(bus.dma_rvalid), 64'(e.dv));
            chk({tag, ".dma_rdata"},  bus.dma_rdata,       e.dd);
            chk({tag, ".dma_err"},    64'(bus.dma_err),    64'(e.de));
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr,
                         input logic [63:0] cwd, input logic dreq, input logic dwe,
                         input logic [31:0] daddr, input logic [63:0] dwd);
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.dma_req   = dreq;
        bus.dma_we    = dwe;
        bus.dma_addr  = daddr;
        bus.dma_wdata = dwd;
    endtask

    // One clock cycle: check last cycle's responses, drive, check grants and memory side.
    task automatic step(input string tag,
                        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [63:0] cwd,
                        input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [63:0] dwd,
                        input logic ecg, input logic edg);
        logic [31:0] ea;
        logic [63:0] ewd;
        logic        ewe, inr;
        resp_t       r;
        @(negedge clk);
        check_resp(tag);
        drive(creq, cwe, caddr, cwd, dreq, dwe, daddr, dwd);
        #1;
        ea  = ecg ? caddr : (edg ? daddr : 32'h0);
        ewd = ecg ? cwd   : (edg ? dwd   : 64'h0);
        ewe = ecg ? cwe   : (edg ? dwe   : 1'b0);
        inr = ea < MEM_BYTES;
        chk({tag, ".cpu_gnt"},   64'(bus.cpu_gnt),   64'(ecg));
        chk({tag, ".dma_gnt"},   64'(bus.dma_gnt),   64'(edg));
        chk({tag, ".cpu_stall"}, 64'(bus.cpu_stall), 64'(creq && !ecg));
        chk({tag, ".mem_en"},    64'(bus.mem_en),    64'((ecg || edg) && inr));
        chk({tag, ".mem_we"},    64'(bus.mem_we),    64'(ewe));
        chk({tag, ".mem_addr"},  64'(bus.mem_addr),  64'(ea));
        chk({tag, ".mem_wdata"}, bus.mem_wdata,      ewd);
        r = '{cv: 1'b0, cd: 64'h0, ce: 1'b0, dv: 1'b0, dd: 64'h0, de: 1'b0};
        if (ecg) begin
            r.cv = !cwe;
            r.cd = (!cwe && inr) ? mem_init(int'(ea[12:3])) : 64'h0;
            r.ce = !inr;
        end
        if (edg) begin
            r.dv = !dwe;
            r.dd = (!dwe && inr) ? mem_init(int'(ea[12:3])) : 64'h0;
            r.de = !inr;
        end
        sb.push_back(r);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    endtask

    task automatic reset_check(input string tag, input logic exp_stall);
        chk({tag, ".cpu_gnt"},    64'(bus.cpu_gnt),    64'(0));
        chk({tag, ".dma_gnt"},    64'(bus.dma_gnt),    64'(0));
        chk({tag, ".cpu_stall"},  64'(bus.cpu_stall),  64'(exp_stall));
        chk({tag, ".mem_en"},     64'(bus.mem_en),     64'(0));
        chk({tag, ".mem_we"},     64'(bus.mem_we),     64'(0));
        chk({tag, ".mem_addr"},   64'(bus.mem_addr),   64'(0));
        chk({tag, ".mem_wdata"},  bus.mem_wdata,       64'(0));
        chk({tag, ".cpu_rvalid"}, 64'(bus.cpu_rvalid), 64'(0));
        chk({tag, ".cpu_rdata"},  bus.cpu_rdata,       64'(0));
        chk({tag, ".cpu_err"},    64'(bus.cpu_err),    64'(0));
        chk({tag, ".dma_rvalid"}, 64'(bus.dma_rvalid), 64'(0));
        chk({tag, ".dma_rdata"},  bus.dma_rdata,       64'(0));
        chk({tag, ".dma_err"},    64'(bus.dma_err),    64'(0));
    endtask

    initial begin
        // Reset with both requesters active: everything gated off, stall follows cpu_req.
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h40, 64'h1234, 1'b1, 1'b0, 32'h48, 64'h5678);
        #12;
        reset_check("reset", 1'b1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0);
        rst = 1'b1;
        sb.push_back('{cv: 1'b0, cd: 64'h0, ce: 1'b0, dv: 1'b0, dd: 64'h0, de: 1'b0});

        idle("idle0");

        // CPU-only writes.
        for (int i = 0; i < 3; i++) begin
            step("cpu_wr", 1'b1, 1'b1, 32'(i * 8), 64'(32'h1111 * (i + 1)),
                 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        end
        idle("cpu_wr_done");

        // Both ports read continuously: CPU, 4x DMA, CPU, 4x DMA.
        for (int i = 0; i < 10; i++) begin
            step("both_rd", 1'b1, 1'b0, 32'h20, 64'h0, 1'b1, 1'b0, 32'h28, 64'h0,
                 (i == 0 || i == 5), !(i == 0 || i == 5));
        end
        idle("both_rd_done");

        // Back-to-back reads to different owners.
        step("b2b_cpu", 1'b1, 1'b0, 32'h20, 64'h0, 1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0);
        step("b2b_dma", 1'b0, 1'b0, 32'h0,  64'h0, 1'b1, 1'b0, 32'h28, 64'h0, 1'b0, 1'b1);
        idle("b2b_done");

        // Out-of-range and last-legal-word accesses.
        step("oor_rd",   1'b1, 1'b0, 32'd8192, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step("last_rd",  1'b1, 1'b0, 32'd8184, 64'h0, 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        step("oor_wr",   1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, 32'hFFFF_FFF8, 64'hDEAD, 1'b0, 1'b1);
        idle("oor_done");
        idle("oor_quiet");

        // DMA streaming alone, then CPU arrives once the burst count is saturated.
        for (int i = 0; i < 10; i++) begin
            step("dma_burst", 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'(32'h100 + i * 8), 64'h0,
                 1'b0, 1'b1);
        end
        step("burst_cpu", 1'b1, 1'b0, 32'h200, 64'h0, 1'b1, 1'b0, 32'h150, 64'h0, 1'b1, 1'b0);
        step("burst_rr",  1'b0, 1'b0, 32'h0,   64'h0, 1'b1, 1'b0, 32'h158, 64'h0, 1'b0, 1'b1);
        idle("burst_done");

        // DMA read in flight when reset pulses: its response is discarded.
        step("pre_rst", 1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 32'h30, 64'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        drive(1'b1, 1'b0, 32'h38, 64'h0, 1'b1, 1'b0, 32'h40, 64'h0);
        @(negedge clk);
        reset_check("mid_rst", 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back('{cv: 1'b0, cd: 64'h0, ce: 1'b0, dv: 1'b0, dd: 64'h0, de: 1'b0});
        step("post_rst", 1'b1, 1'b0, 32'h38, 64'h0, 1'b1, 1'b0, 32'h40, 64'h0, 1'b1, 1'b0);
        step("post_rr",  1'b1, 1'b0, 32'h38, 64'h0, 1'b1, 1'b0, 32'h40, 64'h0, 1'b0, 1'b1);
        idle("post_done");
        idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
